// File: rtl/entrada_dados.sv
// User input unit: debounced confirm button captures sign-extended Switches into Dado.
// Press/release take DEB_CYCLES+2 cycles each; Stall holds the pipeline from IO==2'b10 until DONE.
module entrada_dados #(
    parameter int DEB_CYCLES = 50000
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic [1:0]  IO,
    input  logic [10:0] Switches,
    input  logic        Botao,
    output logic [31:0] Dado,
    output logic        Pronto,
    output logic        Stall,
    output logic        IOLED
);

    localparam int CW = $clog2(DEB_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        WAIT_PRESS   = 2'd1,
        WAIT_RELEASE = 2'd2,
        DONE         = 2'd3
    } state_t;

    state_t        state;
    logic          sync1;
    logic          sync2;
    logic          deb_level;
    logic [CW-1:0] deb_cnt;
    logic          pronto_q;
    logic          ioled_q;
    logic          io_req;
    logic          flip;
    logic          press;
    logic          release_evt;

    assign io_req = (IO == 2'b10);

    // The level flips on the DEB_CYCLES-th consecutive differing cycle; that same
    // cycle is the press/release event seen by the FSM.
    assign flip        = (sync2 != deb_level) && (deb_cnt == CW'(DEB_CYCLES - 1));
    assign press       = flip && deb_level;
    assign release_evt = flip && !deb_level;

    always_ff @(posedge CLK) begin
        if (Reset) begin
            sync1     <= 1'b1;
            sync2     <= 1'b1;
            deb_level <= 1'b1;
            deb_cnt   <= '0;
        end else begin
            sync1 <= Botao;
            sync2 <= sync1;
            if (sync2 == deb_level) begin
                deb_cnt <= '0;
            end else if (flip) begin
                deb_level <= sync2;
                deb_cnt   <= '0;
            end else begin
                deb_cnt <= deb_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state    <= IDLE;
            Dado     <= '0;
            pronto_q <= 1'b0;
            ioled_q  <= 1'b0;
        end else begin
            pronto_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (io_req) begin
                        state   <= WAIT_PRESS;
                        ioled_q <= 1'b1;
                    end
                end
                WAIT_PRESS: begin
                    if (!io_req) begin
                        state   <= IDLE;
                        ioled_q <= 1'b0;
                    end else if (press) begin
                        Dado  <= {{21{Switches[10]}}, Switches};
                        state <= WAIT_RELEASE;
                    end
                end
                WAIT_RELEASE: begin
                    if (!io_req) begin
                        state   <= IDLE;
                        ioled_q <= 1'b0;
                    end else if (release_evt) begin
                        state    <= DONE;
                        ioled_q  <= 1'b0;
                        pronto_q <= 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    ioled_q <= 1'b0;
                end
            endcase
        end
    end

    // Combinational so the stall starts in the very cycle the instruction shows up.
    assign Stall  = io_req && (state != DONE);
    assign Pronto = pronto_q;
    assign IOLED  = ioled_q;

endmodule

// File: tb/tb_entrada_dados.sv
// Bench for entrada_dados with DEB_CYCLES = 4: vector table plus hand-written corner sequences.
module tb_entrada_dados;

    logic        CLK;
    logic        Reset;
    logic [1:0]  IO;
    logic [10:0] Switches;
    logic        Botao;
    logic [31:0] Dado;
    logic        Pronto;
    logic        Stall;
    logic        IOLED;

    int n_total = 0;
    int n_pass  = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_cap;

    entrada_dados #(.DEB_CYCLES(4)) dut (
        .CLK(CLK), .Reset(Reset), .IO(IO), .Switches(Switches), .Botao(Botao),
        .Dado(Dado), .Pronto(Pronto), .Stall(Stall), .IOLED(IOLED)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Each Pronto pulse must carry the oldest outstanding expected capture.
    always @(negedge CLK) begin
        if (Pronto === 1'b1) begin
            if (exp_q.size() == 0) check("unexpected_pronto", 32'd1, 32'd0);
            else check("pronto_dado", Dado, exp_q.pop_front());
        end
    end

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge CLK);
    endtask

    task automatic wait_pronto(output bit seen, output bit stall_ok);
        seen = 0;
        stall_ok = 1;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge CLK);
            if (Pronto === 1'b1) seen = 1;
            else if (Stall !== 1'b1) stall_ok = 0;
        end
        if (!seen) check("pronto_timeout", 32'd0, 32'd1);
    endtask

    task automatic run_input(input logic [10:0] sw, input logic [31:0] exp, input bit keep_io);
        bit seen;
        bit stall_ok;
        bit stall_ok2;
        IO = 2'b10;
        Switches = sw;
        #1;
        check("stall_start", {31'd0, Stall}, 32'd1);
        Botao = 1'b0;
        stall_ok = 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            if (Stall !== 1'b1) stall_ok = 0;
        end
        check("ioled_wait", {31'd0, IOLED}, 32'd1);
        check("dado_capture", Dado, exp);
        exp_q.push_back(exp);
        last_cap = exp;
        Switches = ~sw;
        Botao = 1'b1;
        wait_pronto(seen, stall_ok2);
        check("stall_held", {31'd0, stall_ok & stall_ok2}, 32'd1);
        if (seen) begin
            check("stall_done", {31'd0, Stall}, 32'd0);
            check("ioled_done", {31'd0, IOLED}, 32'd0);
        end
        if (!keep_io) IO = 2'b00;
        @(negedge CLK);
        check("pronto_single", {31'd0, Pronto}, 32'd0);
        if (keep_io) begin
            @(negedge CLK);
            check("b2b_rewait", {31'd0, IOLED}, 32'd1);
        end
    endtask

    typedef struct {
        logic [10:0] sw;
        logic [31:0] exp_dado;
        bit          keep_io;
    } vec_t;

    vec_t vecs[6];

    initial begin
        bit seen;
        bit stall_ok;

        vecs[0] = '{11'h005, 32'h00000005, 1'b0};
        vecs[1] = '{11'h7FF, 32'hFFFFFFFF, 1'b1};
        vecs[2] = '{11'h400, 32'hFFFFFC00, 1'b0};
        vecs[3] = '{11'h3FF, 32'h000003FF, 1'b1};
        vecs[4] = '{11'h555, 32'hFFFFFD55, 1'b1};
        vecs[5] = '{11'h2AA, 32'h000002AA, 1'b0};

        Reset = 1'b1;
        IO = 2'b00;
        Switches = '0;
        Botao = 1'b1;
        last_cap = '0;

        cycles(2);
        check("rst_dado", Dado, 32'd0);
        check("rst_pronto", {31'd0, Pronto}, 32'd0);
        check("rst_ioled", {31'd0, IOLED}, 32'd0);
        check("rst_stall_idle", {31'd0, Stall}, 32'd0);
        IO = 2'b10;
        #1;
        check("rst_stall_io", {31'd0, Stall}, 32'd1);
        cycles(1);
        check("rst_holds_idle", {31'd0, IOLED}, 32'd0);
        IO = 2'b00;
        Reset = 1'b0;
        cycles(2);

        for (int v = 0; v < 6; v++) run_input(vecs[v].sw, vecs[v].exp_dado, vecs[v].keep_io);

        // Bouncing button: every bounce shorter than the debounce window.
        IO = 2'b10;
        Switches = 11'h123;
        for (int i = 0; i < 20; i++) begin
            Botao = ((i / 2) % 2) ? 1'b1 : 1'b0;
            @(negedge CLK);
        end
        check("bounce_ioled", {31'd0, IOLED}, 32'd1);
        check("bounce_no_capture", Dado, last_cap);
        Botao = 1'b0;
        cycles(6);
        check("bounce_capture", Dado, 32'h00000123);
        exp_q.push_back(32'h00000123);
        last_cap = 32'h00000123;
        Botao = 1'b1;
        wait_pronto(seen, stall_ok);
        IO = 2'b00;
        cycles(2);

        // Abort before the press.
        IO = 2'b10;
        Switches = 11'h0F0;
        cycles(3);
        check("abort_waiting", {31'd0, IOLED}, 32'd1);
        IO = 2'b00;
        cycles(1);
        check("abort_idle", {31'd0, IOLED}, 32'd0);
        Botao = 1'b0;
        cycles(8);
        Botao = 1'b1;
        cycles(8);
        check("abort_dado", Dado, last_cap);

        // Button already held when the instruction arrives.
        Botao = 1'b0;
        cycles(8);
        IO = 2'b10;
        Switches = 11'h0AA;
        cycles(8);
        check("held_no_capture", Dado, last_cap);
        check("held_ioled", {31'd0, IOLED}, 32'd1);
        Botao = 1'b1;
        cycles(8);
        check("held_release_no_capture", Dado, last_cap);
        Botao = 1'b0;
        cycles(8);
        check("held_repress_capture", Dado, 32'h000000AA);
        exp_q.push_back(32'h000000AA);
        last_cap = 32'h000000AA;
        Botao = 1'b1;
        wait_pronto(seen, stall_ok);
        IO = 2'b00;
        cycles(2);

        // Reset while waiting for the release.
        IO = 2'b10;
        Switches = 11'h055;
        Botao = 1'b0;
        cycles(8);
        check("mid_capture", Dado, 32'h00000055);
        Reset = 1'b1;
        cycles(1);
        check("mid_rst_dado", Dado, 32'd0);
        check("mid_rst_ioled", {31'd0, IOLED}, 32'd0);
        check("mid_rst_pronto", {31'd0, Pronto}, 32'd0);
        check("mid_rst_stall", {31'd0, Stall}, 32'd1);
        Reset = 1'b0;
        IO = 2'b00;
        Botao = 1'b1;
        cycles(10);
        check("post_rst_ioled", {31'd0, IOLED}, 32'd0);
        check("post_rst_dado", Dado, 32'd0);

        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/entrada_dados.md
ENTRADA_DADOS -- requirements
Module: entrada_dados

Interface
REQ-001 SHALL have parameter: DEB_CYCLES, 50000, consecutive stable synchronized cycles needed to accept a Botao level change (range 2..2^20).
REQ-002 SHALL have port: CLK  input  1  system clock; all state updates on rising edge.
REQ-003 SHALL have port: Reset  input  1  reset Reset, synchronous, active-high.
REQ-004 SHALL have port: IO  input  2  I/O control from control unit; 2'b10 = input instruction, other values = no input request.
REQ-005 SHALL have port: Switches  input  11  user data switches, two's complement.
REQ-006 SHALL have port: Botao  input  1  confirm pushbutton, active-low, asynchronous to CLK, bouncing.
REQ-007 SHALL have port: Dado  output  32  captured input value, sign-extended, to register-file write mux.
REQ-008 SHALL have port: Pronto  output  1  one-cycle pulse: Dado valid, input instruction completes this cycle.
REQ-009 SHALL have port: Stall  output  1  freeze PC/pipeline while input pending.
REQ-010 SHALL have port: IOLED  output  1  waiting-for-user indicator.

Function
REQ-011 SHALL pass Botao through a 2-flop synchronizer before any other use.
REQ-012 SHALL hold a debounced level (1 = released) that changes only after the synchronized Botao differs from it for DEB_CYCLES consecutive cycles; counter clears on any cycle where they match.
REQ-013 SHALL define press = debounced level 1->0 transition, release = debounced 0->1 transition, each a single-cycle event.
REQ-014 SHALL implement FSM states IDLE, WAIT_PRESS, WAIT_RELEASE, DONE.
REQ-015 SHALL in IDLE move to WAIT_PRESS when IO == 2'b10; otherwise stay.
REQ-016 SHALL in WAIT_PRESS, on press, load Dado = {21{Switches[10]}, Switches} and move to WAIT_RELEASE; Switches sampled on the press cycle only.
REQ-017 SHALL in WAIT_RELEASE, on release, move to DONE; Dado unchanged.
REQ-018 SHALL in DONE unconditionally return to IDLE after one cycle.
REQ-019 SHALL drive Stall combinationally = (IO == 2'b10) AND (state != DONE), so the stall begins in the same cycle the input instruction appears.
REQ-020 SHALL drive Pronto = 1 exactly when state == DONE, else 0.
REQ-021 SHALL drive IOLED = 1 in WAIT_PRESS and WAIT_RELEASE, else 0.
REQ-022 SHALL hold Dado at last captured value until the next capture.
REQ-023 SHALL abort to IDLE from WAIT_PRESS or WAIT_RELEASE if IO != 2'b10 (no capture in that cycle, Pronto stays 0, Dado keeps prior value).
REQ-024 SHALL ignore presses/releases outside WAIT_PRESS/WAIT_RELEASE; a button already held when IO becomes 2'b10 SHALL NOT capture until released and pressed again.
REQ-025 SHALL support back-to-back input instructions: IO == 2'b10 in IDLE right after DONE starts a new wait.
REQ-026 SHALL keep the debounce path running in all states so state entry does not restart debouncing.

Reset
REQ-027 SHALL on Reset high at a clock edge set: state IDLE, Dado 0, synchronizer flops 1, debounced level 1, debounce counter 0; hence Pronto 0, IOLED 0.
REQ-028 SHALL give Reset priority over all other events, including mid-wait and a press in the same cycle.
REQ-029 SHALL keep Stall combinational during reset (Stall = 1 if IO == 2'b10, since state forced IDLE).

Verification (DEB_CYCLES = 4)
REQ-030 SHALL verify basic input: IO=10, Switches=11'h005, Botao low 10 cycles then high -> Stall 1 throughout, IOLED 1, Dado=32'h00000005 after press, single Pronto pulse after release, Stall 0 in DONE cycle.
REQ-031 SHALL verify sign extension: Switches=11'h7FF -> Dado=32'hFFFFFFFF; Switches=11'h400 -> Dado=32'hFFFFFC00.
REQ-032 SHALL verify debounce: Botao toggling every 2 cycles for 20 cycles in WAIT_PRESS -> no capture, state remains WAIT_PRESS; then low 6 cycles -> capture.
REQ-033 SHALL verify abort: IO=10 to WAIT_PRESS, IO->00 before press -> IDLE next cycle, Pronto never 1, Dado unchanged.
REQ-034 SHALL verify held button: Botao low before IO=10 -> no capture until release then new press.
REQ-035 SHALL verify reset mid-operation: Reset in WAIT_RELEASE -> next cycle state IDLE, Dado 0, IOLED 0, no Pronto.
